// File: rtl/inst_loop_ctrl.sv
// Instruction sequencer: walks the program from address 0 to the configured end
// address, repeats one loop body a programmed number of times and freezes the PC
// while the datapath stalls.
module inst_loop_ctrl #(
  parameter int unsigned InstMemDepth   = 128,
  parameter int unsigned LoopCountWidth = 16,
  parameter int unsigned InstAddrWidth  = $clog2(InstMemDepth)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      clr_i,
  input  logic                      stall_i,
  input  logic [InstAddrWidth-1:0]  cfg_prog_end_addr_i,
  input  logic [InstAddrWidth-1:0]  cfg_loop_start_addr_i,
  input  logic [InstAddrWidth-1:0]  cfg_loop_end_addr_i,
  input  logic [LoopCountWidth-1:0] cfg_loop_count_i,
  output logic [InstAddrWidth-1:0]  inst_addr_o,
  output logic                      inst_en_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [LoopCountWidth-1:0] loop_iter_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                    r_state, w_state_next;
  logic [InstAddrWidth-1:0]  r_pc, w_pc_next;
  logic [LoopCountWidth-1:0] r_iter, w_iter_next;

  logic [InstAddrWidth-1:0]  r_prog_end, r_loop_start, r_loop_end;
  logic [LoopCountWidth-1:0] r_eff_count;

  logic                      w_cfg_latch;
  logic                      w_loop_valid;
  logic                      w_loop_back;
  logic [LoopCountWidth:0]   w_iter_inc;
  logic [InstAddrWidth-1:0]  w_pc_inc;

  assign w_cfg_latch  = (r_state == StIdle) && start_i && !clr_i;
  // A loop that is inverted or reaches past the program end is ignored entirely.
  assign w_loop_valid = (r_loop_start <= r_loop_end) && (r_loop_end <= r_prog_end);
  // One extra bit keeps the +1 comparison exact even at the counter limit.
  assign w_iter_inc   = {1'b0, r_iter} + {{LoopCountWidth{1'b0}}, 1'b1};
  assign w_loop_back  = w_loop_valid && (r_pc == r_loop_end) &&
                        (w_iter_inc < {1'b0, r_eff_count});
  // Wrap explicitly so non-power-of-two depths still stay inside the memory.
  assign w_pc_inc     = (r_pc == InstAddrWidth'(InstMemDepth - 1)) ? '0 :
                        r_pc + InstAddrWidth'(1);

  // Latch configuration at start; a zero loop count behaves as a single pass.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prog_end   <= '0;
      r_loop_start <= '0;
      r_loop_end   <= '0;
      r_eff_count  <= '0;
    end else if (w_cfg_latch) begin
      r_prog_end   <= cfg_prog_end_addr_i;
      r_loop_start <= cfg_loop_start_addr_i;
      r_loop_end   <= cfg_loop_end_addr_i;
      r_eff_count  <= (cfg_loop_count_i == '0) ? LoopCountWidth'(1) : cfg_loop_count_i;
    end
  end

  // State, PC and iteration registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_iter  <= w_iter_next;
    end
  end

  // Next state: clear wins, then the per-state rules; stalls hold everything.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_iter_next  = r_iter;
    if (clr_i) begin
      w_state_next = StIdle;
      w_pc_next    = '0;
      w_iter_next  = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            w_state_next = StRun;
            w_pc_next    = '0;
            w_iter_next  = '0;
          end
        end
        StRun: begin
          if (!stall_i) begin
            if (w_loop_back) begin
              w_pc_next   = r_loop_start;
              w_iter_next = w_iter_inc[LoopCountWidth-1:0];
            end else if (r_pc == r_prog_end) begin
              w_state_next = StDone;
              w_iter_next  = '0;
            end else begin
              w_pc_next = w_pc_inc;
              if (r_pc == r_loop_end) begin
                w_iter_next = '0;
              end
            end
          end
        end
        StDone: begin
          w_state_next = StIdle;
          w_pc_next    = '0;
        end
        default: begin
          w_state_next = StIdle;
          w_pc_next    = '0;
          w_iter_next  = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the state register; enable also gated by stall.
  always_comb begin
    inst_addr_o = r_pc;
    loop_iter_o = r_iter;
    inst_en_o   = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      StRun: begin
        busy_o    = 1'b1;
        inst_en_o = !stall_i;
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
